// File: rtl/i2c_oled_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : i2c_oled_init_seq
// Brief    : SSD1306 power-up sequencer: delay, init command stream, GDDRAM clear
// Revision : 1.0 - initial release
// ============================================================================
module i2c_oled_init_seq #(
  parameter logic [6:0]  SLAVE_ADDR     = 7'h3C,
  parameter logic [7:0]  MUX_RATIO      = 8'h3F,
  parameter logic [7:0]  COM_PINS       = 8'h12,
  parameter logic [7:0]  CONTRAST       = 8'hCF,
  parameter int unsigned CLEAR_BYTES    = 1024,
  parameter int unsigned POWERUP_CYCLES = 100000
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [6:0] m_slave_addr,
  output logic       m_read_write,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  input  logic       m_nack
);

  localparam int unsigned CLR_W  = (CLEAR_BYTES > 0) ? $clog2(CLEAR_BYTES + 1) : 1;
  localparam int unsigned WAIT_W = (POWERUP_CYCLES > 0) ? $clog2(POWERUP_CYCLES + 1) : 1;
  localparam logic [4:0]        CMD_LAST  = 5'd24;
  localparam logic [CLR_W-1:0]  CLR_LAST  = (CLEAR_BYTES > 0) ? CLR_W'(CLEAR_BYTES - 1) : '0;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(POWERUP_CYCLES);
  localparam logic              HAS_CLEAR = (CLEAR_BYTES > 0);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PWR_WAIT  = 3'd1,
    CMD_CTRL  = 3'd2,
    CMD_BYTES = 3'd3,
    CLR_CTRL  = 3'd4,
    CLR_DATA  = 3'd5,
    DONE      = 3'd6,
    ERROR     = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        cmd_idx_q, cmd_idx_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              m_valid_q, m_valid_d;
  logic [7:0]        m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic              xfer;
  logic              in_seq;

  function automatic logic [7:0] cmd_byte(input logic [4:0] idx);
    logic [7:0] b;
    case (idx)
      5'd0:    b = 8'hAE;
      5'd1:    b = 8'hD5;
      5'd2:    b = 8'h80;
      5'd3:    b = 8'hA8;
      5'd4:    b = MUX_RATIO;
      5'd5:    b = 8'hD3;
      5'd6:    b = 8'h00;
      5'd7:    b = 8'h40;
      5'd8:    b = 8'h8D;
      5'd9:    b = 8'h14;
      5'd10:   b = 8'h20;
      5'd11:   b = 8'h00;
      5'd12:   b = 8'hA1;
      5'd13:   b = 8'hC8;
      5'd14:   b = 8'hDA;
      5'd15:   b = COM_PINS;
      5'd16:   b = 8'h81;
      5'd17:   b = CONTRAST;
      5'd18:   b = 8'hD9;
      5'd19:   b = 8'hF1;
      5'd20:   b = 8'hDB;
      5'd21:   b = 8'h40;
      5'd22:   b = 8'hA4;
      5'd23:   b = 8'hA6;
      default: b = 8'hAF;
    endcase
    return b;
  endfunction

  always_comb begin
    state_d    = state_q;
    cmd_idx_d  = cmd_idx_q;
    clr_cnt_d  = clr_cnt_q;
    wait_cnt_d = wait_cnt_q;
    xfer       = m_valid_q & m_ready;
    in_seq     = (state_q == PWR_WAIT) || (state_q == CMD_CTRL) || (state_q == CMD_BYTES) ||
                 (state_q == CLR_CTRL) || (state_q == CLR_DATA);

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d    = PWR_WAIT;
          cmd_idx_d  = '0;
          clr_cnt_d  = '0;
          wait_cnt_d = '0;
        end
      end
      // PWR_WAIT lasts POWERUP_CYCLES+1 edges so the first byte lands at N+P+1
      PWR_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = CMD_CTRL;
        else                         wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
      CMD_CTRL: begin
        if (xfer) begin
          state_d   = CMD_BYTES;
          cmd_idx_d = '0;
        end
      end
      CMD_BYTES: begin
        if (xfer) begin
          if (cmd_idx_q == CMD_LAST) state_d = HAS_CLEAR ? CLR_CTRL : DONE;
          else                       cmd_idx_d = cmd_idx_q + 5'd1;
        end
      end
      CLR_CTRL: begin
        if (xfer) begin
          state_d   = CLR_DATA;
          clr_cnt_d = '0;
        end
      end
      CLR_DATA: begin
        if (xfer) begin
          if (clr_cnt_q == CLR_LAST) state_d = DONE;
          else                       clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (in_seq && m_nack) state_d = ERROR;

    // Outputs are registered images of the next state so nothing leaks from m_ready/m_nack
    busy_d    = (state_d == PWR_WAIT) || (state_d == CMD_CTRL) || (state_d == CMD_BYTES) ||
                (state_d == CLR_CTRL) || (state_d == CLR_DATA);
    done_d    = (state_d == DONE);
    error_d   = (state_d == ERROR);
    m_valid_d = (state_d == CMD_CTRL) || (state_d == CMD_BYTES) ||
                (state_d == CLR_CTRL) || (state_d == CLR_DATA);
    m_data_d  = 8'h00;
    m_last_d  = 1'b0;
    case (state_d)
      CMD_BYTES: begin
        m_data_d = cmd_byte(cmd_idx_d);
        m_last_d = (cmd_idx_d == CMD_LAST);
      end
      CLR_CTRL: m_data_d = 8'h40;
      CLR_DATA: m_last_d = (clr_cnt_d == CLR_LAST);
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q    <= IDLE;
      cmd_idx_q  <= '0;
      clr_cnt_q  <= '0;
      wait_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= 8'h00;
      m_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_idx_q  <= cmd_idx_d;
      clr_cnt_q  <= clr_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_last       = m_last_q;
  assign m_slave_addr = SLAVE_ADDR;
  assign m_read_write = 1'b0;

endmodule
`default_nettype wire
